// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_scheduler
//  Description : Round-robin scheduler that shares an 8:1 multiplexer among
//                eight requesters. It drives the registered 3-bit select,
//                a one-hot grant, a busy flag and a one-cycle timeout pulse.
//                A grant ends when the grantee is finished, its request
//                drops, or the hold limit expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_scheduler #(
  parameter int MAX_HOLD = 4    // maximum grant length in cycles, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  // "release" is a reserved SystemVerilog keyword, so the grantee-finished
  // strobe carries this name instead.
  input  logic       release_req,
  output logic [2:0] address,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  // Last value of the hold counter before the limit ends the grant.
  localparam logic [3:0] c_hold_last = 4'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [2:0] w_address_nxt;
  logic [7:0] w_grant_nxt;
  logic       w_busy_nxt;
  logic       w_timeout_nxt;

  logic [7:0] w_rot;
  logic [2:0] w_offset;
  logic [2:0] w_winner;
  logic       w_any;
  logic       w_normal_end;
  logic       w_limit_end;

  // Rotate the request vector so that bit 0 is the requester at the pointer.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 8; i++) begin
      w_rot[i] = req[3'(r_ptr + 3'(i))];
    end
  end

  // Lowest set bit of the rotated vector is the nearest requester at or
  // above the pointer; add the pointer back to get its absolute index.
  always_comb begin
    w_offset = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_offset = 3'(j);
      end
    end
    w_any    = |req;
    w_winner = r_ptr + w_offset;
  end

  // Grant-end conditions; a normal end masks the hold limit so that a
  // simultaneous release never produces a timeout pulse.
  always_comb begin
    w_normal_end = release_req || !req[address];
    w_limit_end  = !w_normal_end && (r_cnt == c_hold_last);
  end

  // Next-state and next-output decode for the two-state scheduler.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_address_nxt = address;
    w_grant_nxt   = grant;
    w_busy_nxt    = busy;
    w_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_any) begin
          w_address_nxt = w_winner;
          w_grant_nxt   = 8'b1 << w_winner;
          w_busy_nxt    = 1'b1;
          w_cnt_nxt     = 4'd0;
          w_state_nxt   = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (w_normal_end || w_limit_end) begin
          // The served requester drops to lowest priority next round.
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = address + 3'd1;
          w_timeout_nxt = w_limit_end;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs; reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_cnt   <= 4'd0;
      address <= 3'd0;
      grant   <= 8'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      address <= w_address_nxt;
      grant   <= w_grant_nxt;
      busy    <= w_busy_nxt;
      timeout <= w_timeout_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_scheduler
//  Description : Scoreboard bench for mux_rr_scheduler. Stimulus predicts the
//                post-edge outputs with a transaction-level model and queues
//                them; a monitor compares every cycle on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_scheduler;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       release_req;
  logic [2:0] address;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  mux_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .release_req (release_req),
    .address     (address),
    .grant       (grant),
    .busy        (busy),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number of the most recent rising edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  addr;
    logic [7:0]  grant;
    logic        busy;
    logic        timeout;
  } exp_t;

  exp_t q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit stim_done   = 1'b0;

  // Reference model: who holds the mux, for how many cycles so far, and
  // which requester has first claim at the next arbitration.
  bit      m_busy    = 1'b0;
  int      m_addr    = 0;
  int      m_served  = 0;
  int      m_first   = 0;
  bit      m_timeout = 1'b0;

  task automatic model(input logic r, input logic [7:0] rq, input logic rl);
    m_timeout = 1'b0;
    if (r) begin
      m_busy   = 1'b0;
      m_addr   = 0;
      m_served = 0;
      m_first  = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (!m_busy && rq[(m_first + k) % 8]) begin
          m_busy   = 1'b1;
          m_addr   = (m_first + k) % 8;
          m_served = 1;
        end
      end
    end else if (rl || !rq[m_addr]) begin
      m_busy  = 1'b0;
      m_first = (m_addr + 1) % 8;
    end else if (m_served == MAX_HOLD) begin
      m_busy    = 1'b0;
      m_first   = (m_addr + 1) % 8;
      m_timeout = 1'b1;
    end else begin
      m_served++;
    end
  endtask

  // Apply one cycle of inputs, queue the predicted post-edge outputs.
  task automatic step(input logic r, input logic [7:0] rq, input logic rl);
    exp_t e;
    reset       = r;
    req         = rq;
    release_req = rl;
    model(r, rq, rl);
    e.cyc     = cyc + 1;
    e.addr    = 3'(m_addr);
    e.grant   = m_busy ? (8'b1 << m_addr) : 8'h00;
    e.busy    = m_busy;
    e.timeout = m_timeout;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    logic [7:0] rq;
    logic       rl;
    logic       r;
    reset = 1'b1; req = 8'hFF; release_req = 1'b0;

    // Reset held two cycles with all requests active.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);

    // Full round robin with wrap, one-cycle grants.
    for (int i = 0; i < 20; i++) step(1'b0, 8'hFF, 1'b1);

    // Sparse requesters, then a request swap during a grant.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h22, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h80, 1'b1);

    // Held request without release: repeated hold-limit timeouts.
    for (int i = 0; i < 12; i++) step(1'b0, 8'h08, 1'b0);

    // Release coincides with the hold limit, then request drop mid-grant.
    step(1'b1, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b1);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Reset in the second cycle of a grant to requester 4.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h11, 1'b1);
    step(1'b0, 8'h11, 1'b1);
    step(1'b0, 8'h11, 1'b1);

    // Randomized traffic; requests often held so the limit is exercised.
    rq = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: rq = 8'($urandom);
        1: rq = 8'b1 << $urandom_range(0, 7);
        2: rq = rq;
        default: rq = (($urandom_range(0, 3) == 0) ? 8'h00 : rq);
      endcase
      rl = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, rq, rl);
    end

    step(1'b0, 8'h00, 1'b0);
    stim_done = 1'b1;
  end

  // Monitor: compare DUT outputs against the expectation for this cycle.
  initial begin
    exp_t e;
    int   drain;
    drain = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_check cyc=%0d: expectation for cycle %0d never compared", cyc, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        vectors++;
        if (address !== e.addr || grant !== e.grant || busy !== e.busy || timeout !== e.timeout) begin
          miscompares++;
          $display("FAIL outputs cyc=%0d: got addr=%0d grant=%02h busy=%0b timeout=%0b, required addr=%0d grant=%02h busy=%0b timeout=%0b",
                   cyc, address, grant, busy, timeout, e.addr, e.grant, e.busy, e.timeout);
        end
      end
      if (stim_done) begin
        drain++;
        if (drain == 3) begin
          vectors++;
          if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked expectations, required 0", q.size());
          end
          $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
          $finish;
        end
      end
    end
  end

  // Bound the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
